// File: rtl/ipsxe_floating_point_pipe_pkg.sv
// rtl/ipsxe_floating_point_pipe_pkg.sv - shared limits, count-width helper and stage-valid vector type
package ipsxe_floating_point_pipe_pkg;

    localparam int STAGES_MAX = 16;

    typedef logic [STAGES_MAX-1:0] stage_vec_t;

    // Bits needed to count 0..n live stages inclusive
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ipsxe_floating_point_pipe_ctrl_v1_0_if.sv
// rtl/ipsxe_floating_point_pipe_ctrl_v1_0_if.sv - producer/consumer handshake bundle (i_flush with IPSXE_FLOATING_POINT_PIPE_FLUSH_EN)
interface ipsxe_floating_point_pipe_ctrl_v1_0_if #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 5
);
    logic              i_aclken;
    logic              i_valid;
    logic              o_ready;
    logic [STAGES-1:0] o_stage_en;
    logic [STAGES-1:0] o_stage_vld;
    logic              o_valid;
    logic              i_ready;
    logic [CNT_W-1:0]  o_count;
    logic              o_busy;
`ifdef IPSXE_FLOATING_POINT_PIPE_FLUSH_EN
    logic              i_flush;

    modport master (output i_aclken, i_valid, i_ready, i_flush,
                    input  o_ready, o_stage_en, o_stage_vld, o_valid, o_count, o_busy);
    modport slave  (input  i_aclken, i_valid, i_ready, i_flush,
                    output o_ready, o_stage_en, o_stage_vld, o_valid, o_count, o_busy);
`else
    modport master (output i_aclken, i_valid, i_ready,
                    input  o_ready, o_stage_en, o_stage_vld, o_valid, o_count, o_busy);
    modport slave  (input  i_aclken, i_valid, i_ready,
                    output o_ready, o_stage_en, o_stage_vld, o_valid, o_count, o_busy);
`endif
endinterface

// File: rtl/ipsxe_floating_point_pipe_stage_v1_0.sv
// rtl/ipsxe_floating_point_pipe_stage_v1_0.sv - one stage valid bit plus its bubble-collapsing enable
module ipsxe_floating_point_pipe_stage_v1_0 (
    input  logic clk,
    input  logic rst,
    input  logic aclken,
    input  logic clr,
    input  logic load,
    input  logic en_dn,
    output logic en,
    output logic vld
);

    // An empty stage may always take data; a full one only when its contents move on
    assign en = aclken & (~vld | en_dn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= 1'b0;
        end else if (clr) begin
            vld <= 1'b0;
        end else if (en) begin
            vld <= load;
        end
    end

endmodule

// File: rtl/ipsxe_floating_point_pipe_ctrl_v1_0.sv
// rtl/ipsxe_floating_point_pipe_ctrl_v1_0.sv - stage valid/stall controller top (optional flush: IPSXE_FLOATING_POINT_PIPE_FLUSH_EN)
module ipsxe_floating_point_pipe_ctrl_v1_0
    import ipsxe_floating_point_pipe_pkg::*;
#(
    parameter int STAGES = 4,
    parameter int CNT_W  = 5
) (
    input  logic i_clk,
    input  logic i_rst,
    ipsxe_floating_point_pipe_ctrl_v1_0_if.slave pipe
);

    if (STAGES < 2 || STAGES > STAGES_MAX || CNT_W < cnt_width(STAGES)) begin : g_bad_cfg
        $error("ipsxe_floating_point_pipe_ctrl_v1_0: STAGES out of range or CNT_W too narrow");
    end

    logic [STAGES-1:0] en;
    logic [STAGES-1:0] vld;
    logic [CNT_W-1:0]  cnt;
    logic              flush;
    logic              accept;
    logic              retire;

`ifdef IPSXE_FLOATING_POINT_PIPE_FLUSH_EN
    assign flush = pipe.i_flush;
`else
    assign flush = 1'b0;
`endif

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic en_k;
        logic vld_k;
        logic en_dn;
        logic load;

        if (k == STAGES - 1) begin : g_last
            assign en_dn = pipe.i_ready;
        end else begin : g_mid
            assign en_dn = g_stage[k+1].en_k;
        end

        // Stage 0 only loads when enabled, and its enable is o_ready, so i_valid alone suffices
        if (k == 0) begin : g_first
            assign load = pipe.i_valid;
        end else begin : g_next
            assign load = vld[k-1];
        end

        ipsxe_floating_point_pipe_stage_v1_0 u_stage (
            .clk    (i_clk),
            .rst    (i_rst),
            .aclken (pipe.i_aclken),
            .clr    (flush),
            .load   (load),
            .en_dn  (en_dn),
            .en     (en_k),
            .vld    (vld_k)
        );

        assign en[k]  = en_k;
        assign vld[k] = vld_k;
    end

    assign pipe.o_ready     = en[0] & ~flush;
    assign pipe.o_valid     = vld[STAGES-1] & ~flush;
    assign pipe.o_stage_en  = en;
    assign pipe.o_stage_vld = vld;
    assign pipe.o_count     = cnt;
    assign pipe.o_busy      = (cnt != '0);

    assign accept = pipe.i_valid & pipe.o_ready;
    assign retire = pipe.o_valid & pipe.i_ready & pipe.i_aclken;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt <= '0;
        end else if (flush) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(accept) - CNT_W'(retire);
        end
    end

endmodule

// File: tb/tb_ipsxe_floating_point_pipe_ctrl_v1_0.sv
// tb/tb_ipsxe_floating_point_pipe_ctrl_v1_0.sv - randomized bench vs slot-movement model (flush checks with IPSXE_FLOATING_POINT_PIPE_FLUSH_EN)
module tb_ipsxe_floating_point_pipe_ctrl_v1_0;
    import ipsxe_floating_point_pipe_pkg::*;

    localparam int S  = 4;
    localparam int CW = 5;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    ipsxe_floating_point_pipe_ctrl_v1_0_if #(.STAGES(S), .CNT_W(CW)) pif ();

    ipsxe_floating_point_pipe_ctrl_v1_0 #(.STAGES(S), .CNT_W(CW)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .pipe  (pif)
    );

    always #5 i_clk = ~i_clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_ret = 0;

    logic [S-1:0] m_vld = '0;
    logic [S-1:0] m_nxt;
    logic [S-1:0] e_en;
    bit           e_ready;
    bit           e_valid;
    stage_vec_t   snap;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Operands are items in slots; the head leaves on ready, others step into a free slot ahead
    task automatic model_eval(input bit v, input bit r, input bit ce, input bit fl);
        m_nxt = m_vld;
        e_en  = '0;
        if (ce) begin
            for (int k = S - 1; k >= 0; k--) begin
                if (!m_nxt[k]) begin
                    e_en[k] = 1'b1;
                end else if (k == S - 1) begin
                    if (r) begin
                        m_nxt[k] = 1'b0;
                        e_en[k]  = 1'b1;
                    end
                end else if (!m_nxt[k+1]) begin
                    m_nxt[k+1] = 1'b1;
                    m_nxt[k]   = 1'b0;
                    e_en[k]    = 1'b1;
                end
            end
        end
        e_ready = e_en[0] && !fl;
        e_valid = m_vld[S-1] && !fl;
        if (e_ready && v) m_nxt[0] = 1'b1;
        if (fl) m_nxt = '0;
    endtask

    task automatic cycle(input bit v, input bit r, input bit ce, input bit fl);
        bit fl_eff;
        pif.i_valid  = v;
        pif.i_ready  = r;
        pif.i_aclken = ce;
`ifdef IPSXE_FLOATING_POINT_PIPE_FLUSH_EN
        pif.i_flush  = fl;
        fl_eff       = fl;
`else
        fl_eff       = 1'b0;
`endif
        #1;
        model_eval(v, r, ce, fl_eff);
        check("o_ready", int'(pif.o_ready), int'(e_ready));
        check("o_stage_en", int'(pif.o_stage_en), int'(e_en));
        check("o_valid", int'(pif.o_valid), int'(e_valid));
        check("o_stage_vld", int'(pif.o_stage_vld), int'(m_vld));
        check("o_count", int'(pif.o_count), $countones(m_vld));
        check("o_busy", int'(pif.o_busy), int'(m_vld != '0));
        if (pif.o_valid && r && ce) n_ret++;
        @(posedge i_clk);
        m_vld = m_nxt;
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && pif.o_count != 0; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        check("drain_count", int'(pif.o_count), 0);
    endtask

    initial begin
        int lat;
        pif.i_valid  = 1'b0;
        pif.i_ready  = 1'b0;
        pif.i_aclken = 1'b1;
`ifdef IPSXE_FLOATING_POINT_PIPE_FLUSH_EN
        pif.i_flush  = 1'b0;
`endif
        repeat (2) @(posedge i_clk);
        #1;
        check("rst_valid", int'(pif.o_valid), 0);
        check("rst_count", int'(pif.o_count), 0);
        check("rst_busy", int'(pif.o_busy), 0);
        check("rst_ready", int'(pif.o_ready), 1);
        i_rst = 1'b0;
        @(posedge i_clk);
        #1;

        // Single operand latency on an empty pipe
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        lat = 1;
        while (!pif.o_valid && lat < 10) begin
            cycle(1'b0, 1'b1, 1'b1, 1'b0);
            lat++;
        end
        check("latency", lat, S);
        drain();
        check("busy_drop", int'(pif.o_busy), 0);

        // Full-rate streaming
        n_ret = 0;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b1, 1'b1, 1'b0);
        drain();
        check("stream_results", n_ret, 20);

        // Fill under back-pressure, then a single ready pulse
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("full_count", int'(pif.o_count), S);
        check("full_ready", int'(pif.o_ready), 0);
        n_ret = 0;
        cycle(1'b1, 1'b1, 1'b1, 1'b0);
        check("pulse_retire", n_ret, 1);
        check("pulse_count", int'(pif.o_count), S);
        drain();

        // Bubble collapse: pattern 1,0,1 while stalled
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
        snap = stage_vec_t'(pif.o_stage_vld);
        check("bubble_vld", int'(snap), 'hC);
        check("bubble_count", int'(pif.o_count), 2);
        drain();

        // Clock-enable freeze mid-stream, then asynchronous reset
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        check("freeze_count", int'(pif.o_count), 3);
        cycle(1'b1, 1'b0, 1'b1, 1'b0);
        pif.i_valid = 1'b0;
        #2 i_rst = 1'b1;
        #1;
        check("arst_valid", int'(pif.o_valid), 0);
        check("arst_vld", int'(pif.o_stage_vld), 0);
        check("arst_count", int'(pif.o_count), 0);
        check("arst_busy", int'(pif.o_busy), 0);
        m_vld = '0;
        #1 i_rst = 1'b0;
        @(posedge i_clk);
        #1;

`ifdef IPSXE_FLOATING_POINT_PIPE_FLUSH_EN
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
        check("pre_flush_count", int'(pif.o_count), 3);
        cycle(1'b1, 1'b0, 1'b1, 1'b1);
        check("flush_count", int'(pif.o_count), 0);
        check("flush_valid", int'(pif.o_valid), 0);
`endif

        // Randomized traffic against the slot model
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 3) != 0,
                  ($urandom % 8) != 0, ($urandom % 40) == 0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
